// File: rtl/icache_tag_array_nway_if.sv
// Access bus between the L1.5 controller and the N-way instruction tag array.
// The controller drives lookups and refill/invalidate writes; the array returns the hit result.
interface icache_tag_array_nway_if #(
  parameter int unsigned NB_WAYS        = 4,
  parameter int unsigned SET_ADDR_WIDTH = 5,
  parameter int unsigned TAG_WIDTH      = 10
);
  logic                      req;
  logic                      gnt;
  logic                      write;
  logic [SET_ADDR_WIDTH-1:0] set_idx;
  logic [TAG_WIDTH-1:0]      tag;
  logic [NB_WAYS-1:0]        way_sel;
  logic                      wvalid;
  logic                      rvalid;
  logic [NB_WAYS-1:0]        hit_way;
  logic                      hit;
  logic                      multi_hit;
  logic [NB_WAYS-1:0]        valid_vec;

  modport master (
    output req, write, set_idx, tag, way_sel, wvalid,
    input  gnt, rvalid, hit_way, hit, multi_hit, valid_vec
  );

  modport slave (
    input  req, write, set_idx, tag, way_sel, wvalid,
    output gnt, rvalid, hit_way, hit, multi_hit, valid_vec
  );
endinterface

// File: rtl/icache_tag_array_nway.sv
// N-way set-associative tag store for the L1.5 instruction cache: parallel lookup,
// refill/invalidate writes and a sequential set-by-set flush engine.
module icache_tag_array_nway #(
  parameter int unsigned NB_WAYS        = 4,
  parameter int unsigned SET_ADDR_WIDTH = 5,
  parameter int unsigned TAG_WIDTH      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  icache_tag_array_nway_if.slave  bus,
  input  logic                    i_flush_req,
  output logic                    o_flush_busy,
  output logic                    o_flush_done
);
  localparam int unsigned NB_SETS = 2 ** SET_ADDR_WIDTH;

  typedef enum logic {StIdle, StFlush} state_e;

  state_e                    r_state, w_state_d;
  logic [SET_ADDR_WIDTH-1:0] r_cnt, w_cnt_d;
  logic                      w_accept;
  logic                      w_last;

  logic [NB_SETS-1:0]        r_valid   [NB_WAYS];
  logic [TAG_WIDTH-1:0]      r_tag_mem [NB_WAYS][NB_SETS];

  logic                      r_rvalid;
  logic [SET_ADDR_WIDTH-1:0] r_set;
  logic [TAG_WIDTH-1:0]      r_tag;
  logic [NB_WAYS-1:0]        w_hit_way;
  logic [NB_WAYS-1:0]        w_valid_vec;

  assign bus.gnt  = (r_state == StIdle);
  assign w_accept = bus.req & bus.gnt;
  assign w_last   = (r_cnt == SET_ADDR_WIDTH'(NB_SETS - 1));

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    o_flush_busy = 1'b0;
    o_flush_done = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_flush_req) begin
          w_state_d = StFlush;
          w_cnt_d   = '0;
        end
      end
      StFlush: begin
        o_flush_busy = 1'b1;
        w_cnt_d      = r_cnt + SET_ADDR_WIDTH'(1);
        if (w_last) begin
          o_flush_done = 1'b1;
          w_state_d    = StIdle;
          w_cnt_d      = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Flush and writes are mutually exclusive: writes need gnt, which is low while flushing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NB_WAYS; w++) r_valid[w] <= '0;
    end else if (r_state == StFlush) begin
      for (int w = 0; w < NB_WAYS; w++) r_valid[w][r_cnt] <= 1'b0;
    end else if (w_accept && bus.write) begin
      for (int w = 0; w < NB_WAYS; w++) begin
        if (bus.way_sel[w]) r_valid[w][bus.set_idx] <= bus.wvalid;
      end
    end
  end

  // Tag bits carry no reset; a tag is only meaningful when its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_accept && bus.write) begin
      for (int w = 0; w < NB_WAYS; w++) begin
        if (bus.way_sel[w]) r_tag_mem[w][bus.set_idx] <= bus.tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_set    <= '0;
      r_tag    <= '0;
    end else begin
      r_rvalid <= w_accept & ~bus.write;
      if (w_accept && !bus.write) begin
        r_set <= bus.set_idx;
        r_tag <= bus.tag;
      end
    end
  end

  always_comb begin
    w_valid_vec = '0;
    w_hit_way   = '0;
    for (int w = 0; w < NB_WAYS; w++) begin
      w_valid_vec[w] = r_valid[w][r_set];
      w_hit_way[w]   = r_valid[w][r_set] && (r_tag_mem[w][r_set] == r_tag);
    end
  end

  assign bus.rvalid    = r_rvalid;
  assign bus.hit_way   = r_rvalid ? w_hit_way : '0;
  assign bus.valid_vec = r_rvalid ? w_valid_vec : '0;
  assign bus.hit       = |bus.hit_way;
  assign bus.multi_hit = |(bus.hit_way & (bus.hit_way - NB_WAYS'(1)));

endmodule

// File: tb/tb_icache_tag_array_nway.sv
// Bench for icache_tag_array_nway: array-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_icache_tag_array_nway;
  localparam int unsigned NW = 4;
  localparam int unsigned SW = 5;
  localparam int unsigned TW = 10;
  localparam int unsigned NS = 2 ** SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0;
  logic flush_busy, flush_done;

  icache_tag_array_nway_if #(.NB_WAYS(NW), .SET_ADDR_WIDTH(SW), .TAG_WIDTH(TW)) bus ();

  icache_tag_array_nway #(.NB_WAYS(NW), .SET_ADDR_WIDTH(SW), .TAG_WIDTH(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_flush_req  (flush_req),
    .o_flush_busy (flush_busy),
    .o_flush_done (flush_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays of the stored contents plus flush progress.
  bit          m_valid [NW][NS];
  logic [TW-1:0] m_tags [NW][NS];
  bit          m_rvalid;
  int          m_set;
  logic [TW-1:0] m_tag;
  bit          m_flush;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NW; w++) for (int s = 0; s < NS; s++) m_valid[w][s] = 0;
      m_rvalid = 0;
      m_flush  = 0;
      m_cnt    = 0;
    end else begin
      bit acc;
      acc      = bus.req && !m_flush;
      m_rvalid = acc && !bus.write;
      if (m_rvalid) begin
        m_set = int'(bus.set_idx);
        m_tag = bus.tag;
      end
      if (acc && bus.write) begin
        for (int w = 0; w < NW; w++) begin
          if (bus.way_sel[w]) begin
            m_valid[w][bus.set_idx] = bus.wvalid;
            m_tags[w][bus.set_idx]  = bus.tag;
          end
        end
      end
      if (m_flush) begin
        for (int w = 0; w < NW; w++) m_valid[w][m_cnt] = 0;
        if (m_cnt == NS - 1) begin
          m_flush = 0;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end else if (flush_req) begin
        m_flush = 1;
        m_cnt   = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [NW-1:0] hw, vv;
    hw = '0;
    vv = '0;
    if (m_rvalid) begin
      for (int w = 0; w < NW; w++) begin
        vv[w] = m_valid[w][m_set];
        hw[w] = m_valid[w][m_set] && (m_tags[w][m_set] == m_tag);
      end
    end
    chk("gnt", 32'(bus.gnt), 32'(!m_flush));
    chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    chk("hit_way", 32'(bus.hit_way), 32'(hw));
    chk("valid_vec", 32'(bus.valid_vec), 32'(vv));
    chk("hit", 32'(bus.hit), 32'(hw != 0));
    chk("multi_hit", 32'(bus.multi_hit), 32'($countones(hw) > 1));
    chk("flush_busy", 32'(flush_busy), 32'(m_flush));
    chk("flush_done", 32'(flush_done), 32'(m_flush && m_cnt == NS - 1));
  end

  task automatic idle_inputs();
    bus.req = 0; bus.write = 0; bus.set_idx = '0; bus.tag = '0;
    bus.way_sel = '0; bus.wvalid = 0; flush_req = 0;
  endtask

  task automatic wr(input int s, input int t, input logic [NW-1:0] ws, input bit wv);
    @(posedge clk); #2;
    bus.req = 1; bus.write = 1; bus.set_idx = SW'(s); bus.tag = TW'(t);
    bus.way_sel = ws; bus.wvalid = wv;
    @(posedge clk); #2;
    idle_inputs();
  endtask

  // Returns in the negedge of the cycle that carries the lookup result.
  task automatic lookup(input int s, input int t);
    @(posedge clk); #2;
    bus.req = 1; bus.write = 0; bus.set_idx = SW'(s); bus.tag = TW'(t);
    @(posedge clk); #2;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #2;
    flush_req = 1;
    @(posedge clk); #2;
    flush_req = 0;
  endtask

  initial begin
    int busy_cycles, done_at, gnt_hi, done_cnt;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'h1);
    chk("rst_busy", 32'(flush_busy), 32'h0);

    lookup(3, 'h155);
    chk("t1_rvalid", 32'(bus.rvalid), 32'h1);
    chk("t1_hit", 32'(bus.hit), 32'h0);
    chk("t1_vv", 32'(bus.valid_vec), 32'h0);

    wr(3, 'h155, 4'b0100, 1);
    lookup(3, 'h155);
    chk("t2_hitway", 32'(bus.hit_way), 32'h4);
    chk("t2_hit", 32'(bus.hit), 32'h1);
    chk("t2_vv", 32'(bus.valid_vec), 32'h4);
    lookup(3, 'h154);
    chk("t2_miss", 32'(bus.hit), 32'h0);

    wr(3, 'h155, 4'b0100, 0);
    lookup(3, 'h155);
    chk("t5_hit", 32'(bus.hit), 32'h0);
    chk("t5_vv", 32'(bus.valid_vec), 32'h0);

    wr(7, 'h2AA, 4'b0101, 1);
    lookup(7, 'h2AA);
    chk("t3_hitway", 32'(bus.hit_way), 32'h5);
    chk("t3_multi", 32'(bus.multi_hit), 32'h1);

    wr(0, 'h011, 4'b0001, 1);
    wr(31, 'h3FF, 4'b1000, 1);
    lookup(31, 'h3FF);
    chk("t4_prehit", 32'(bus.hit_way), 32'h8);
    pulse_flush();
    busy_cycles = 0; done_at = 0; gnt_hi = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!flush_busy) break;
      busy_cycles++;
      if (bus.gnt) gnt_hi++;
      if (flush_done) done_at = i;
    end
    chk("t4_busy_cycles", 32'(busy_cycles), 32'd32);
    chk("t4_done_at", 32'(done_at), 32'd32);
    chk("t4_gnt_in_flush", 32'(gnt_hi), 32'd0);
    lookup(0, 'h011);
    chk("t4_set0_hit", 32'(bus.hit), 32'h0);
    chk("t4_set0_vv", 32'(bus.valid_vec), 32'h0);
    lookup(31, 'h3FF);
    chk("t4_set31_hit", 32'(bus.hit), 32'h0);
    chk("t4_set31_vv", 32'(bus.valid_vec), 32'h0);

    wr(20, 'h123, 4'b0010, 1);
    wr(3, 'h155, 4'b1111, 1);
    pulse_flush();
    repeat (9) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_busy", 32'(flush_busy), 32'h0);
    chk("t6_done", 32'(flush_done), 32'h0);
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk("t6_gnt", 32'(bus.gnt), 32'h1);
    lookup(20, 'h123);
    chk("t6_hit20", 32'(bus.hit), 32'h0);
    lookup(3, 'h155);
    chk("t6_hit3", 32'(bus.hit), 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (flush_done) done_cnt++;
    end
    chk("t6_no_done", 32'(done_cnt), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      bus.req     = ($urandom_range(0, 9) < 7);
      bus.write   = ($urandom_range(0, 9) < 4);
      bus.set_idx = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'($urandom_range(0, 3));
      bus.tag     = TW'($urandom_range(0, 3));
      bus.way_sel = NW'($urandom);
      bus.wvalid  = ($urandom_range(0, 9) < 8);
      flush_req   = ($urandom_range(0, 99) < 2);
    end
    @(posedge clk); #2;
    idle_inputs();
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
